button_debouncer: RTL and testbench

//  Debounce/event stage directly downstream of the button 2-FF synchronizer; consumes its

---
 rtl/button_debouncer_pkg.sv | 18 +
 rtl/button_debouncer_sat_counter.sv | 36 +++
 rtl/button_debouncer.sv | 143 ++++++++++++++
 tb/tb_button_debouncer.sv | 109 ++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared state encodings and sizing helpers for the button-handling blocks.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StPressWait   = 2'd1,
        StHeld        = 2'd2,
        StReleaseWait = 2'd3
    } state_e;

    // Counter width able to hold the larger of two cycle limits.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_sat_counter.sv
// Up-counter that holds at MAX; clear takes priority over increment.
module button_debouncer_sat_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

    logic [WIDTH-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MaxVal)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces the synchronized button level and emits press/release/long-press pulses.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 4,
    parameter int unsigned LONG_PRESS_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_button,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int unsigned CNT_WIDTH = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);
    localparam logic [CNT_WIDTH-1:0] DebLast  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LongLast = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);

    state_e state_d, state_q;
    logic   pressed_d, pressed_q;
    logic   press_d, press_q;
    logic   release_d, release_q;
    logic   long_d, long_q;

    logic                 deb_clr, deb_inc, hold_clr, hold_inc;
    logic [CNT_WIDTH-1:0] deb_cnt, hold_cnt;

    button_debouncer_sat_counter #(
        .WIDTH (CNT_WIDTH),
        .MAX   (DEBOUNCE_CYCLES - 1)
    ) u_deb_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (deb_clr),
        .inc   (deb_inc),
        .count (deb_cnt)
    );

    // Saturates at LONG_PRESS_CYCLES so the long-press compare can only match once.
    button_debouncer_sat_counter #(
        .WIDTH (CNT_WIDTH),
        .MAX   (LONG_PRESS_CYCLES)
    ) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (hold_clr),
        .inc   (hold_inc),
        .count (hold_cnt)
    );

    always_comb begin
        state_d   = state_q;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        deb_clr   = 1'b0;
        deb_inc   = 1'b0;
        hold_clr  = 1'b0;
        hold_inc  = 1'b0;
        case (state_q)
            StIdle: begin
                pressed_d = 1'b0;
                hold_clr  = 1'b1;
                if (sync_button) begin
                    state_d = StPressWait;
                    deb_inc = 1'b1;
                end else begin
                    deb_clr = 1'b1;
                end
            end
            StPressWait: begin
                if (!sync_button) begin
                    state_d = StIdle;
                    deb_clr = 1'b1;
                end else if (deb_cnt == DebLast) begin
                    state_d   = StHeld;
                    pressed_d = 1'b1;
                    press_d   = 1'b1;
                    deb_clr   = 1'b1;
                    hold_clr  = 1'b1;
                end else begin
                    deb_inc = 1'b1;
                end
            end
            StHeld: begin
                if (!sync_button) begin
                    state_d = StReleaseWait;
                    deb_inc = 1'b1;
                end else begin
                    deb_clr  = 1'b1;
                    hold_inc = 1'b1;
                    long_d   = (hold_cnt == LongLast);
                end
            end
            StReleaseWait: begin
                // hold_cnt is left alone so a release bounce cannot re-arm long press.
                if (sync_button) begin
                    state_d = StHeld;
                    deb_clr = 1'b1;
                end else if (deb_cnt == DebLast) begin
                    state_d   = StIdle;
                    pressed_d = 1'b0;
                    release_d = 1'b1;
                    deb_clr   = 1'b1;
                    hold_clr  = 1'b1;
                end else begin
                    deb_inc = 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                pressed_d = 1'b0;
                deb_clr   = 1'b1;
                hold_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign pressed          = pressed_q;
    assign press_pulse      = press_q;
    assign release_pulse    = release_q;
    assign long_press_pulse = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed scenarios for button_debouncer with a queue of expected output vectors.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sync_button = 1'b0;
    logic pressed, press_pulse, release_pulse, long_press_pulse;

    int checks = 0;
    int errors = 0;

    // Vector order: {pressed, press_pulse, release_pulse, long_press_pulse}
    localparam logic [3:0] Z  = 4'b0000;
    localparam logic [3:0] P  = 4'b1000;
    localparam logic [3:0] PP = 4'b1100;
    localparam logic [3:0] R  = 4'b0010;
    localparam logic [3:0] L  = 4'b1001;

    logic [3:0] exp_q[$];

    button_debouncer #(
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (10)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sync_button      (sync_button),
        .pressed          (pressed),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic btn, input logic [3:0] exp,
                        input string tag);
        logic [3:0] got;
        logic [3:0] want;
        reset       = rst;
        sync_button = btn;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got  = {pressed, press_pulse, release_pulse, long_press_pulse};
        want = exp_q.pop_front();
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    task automatic run(input logic btn, input int n, input logic [3:0] exp, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, btn, exp, tag);
    endtask

    initial begin
        step(1'b1, 1'b0, Z, "reset_state");
        step(1'b1, 1'b1, Z, "reset_ignores_button");

        // Clean press, then long press held 20 cycles past press_pulse
        run(1'b1, 3, Z, "clean_press_wait");
        step(1'b0, 1'b1, PP, "clean_press_pulse");
        run(1'b1, 9, P, "long_wait");
        step(1'b0, 1'b1, L, "long_pulse");
        run(1'b1, 10, P, "long_no_refire");
        // Release bounce after long press must not re-arm it
        step(1'b0, 1'b0, P, "rel_bounce0");
        run(1'b1, 12, P, "long_no_refire_after_bounce");
        run(1'b0, 3, P, "clean_release_wait");
        step(1'b0, 1'b0, R, "clean_release_pulse");
        run(1'b0, 2, Z, "idle_after_release");

        // Bounce on press: 1,1,0,1,1,1,1
        run(1'b1, 2, Z, "bounce_head");
        step(1'b0, 1'b0, Z, "bounce_gap");
        run(1'b1, 3, Z, "bounce_tail");
        step(1'b0, 1'b1, PP, "bounce_press_pulse");

        // Bouncy release 0,1,0,0,0,0 within the long-press window
        step(1'b0, 1'b0, P, "brel_0");
        step(1'b0, 1'b1, P, "brel_1");
        run(1'b0, 3, P, "brel_wait");
        step(1'b0, 1'b0, R, "brel_release_pulse");
        run(1'b0, 12, Z, "brel_no_long");

        // Single-cycle glitch, then a full debounce proves the FSM went back to idle
        step(1'b0, 1'b1, Z, "glitch_high");
        run(1'b0, 3, Z, "glitch_low");
        run(1'b1, 3, Z, "post_glitch_wait");
        step(1'b0, 1'b1, PP, "post_glitch_press");

        // Reset while held with the button still down
        run(1'b1, 3, P, "held_before_reset");
        step(1'b1, 1'b1, Z, "reset_in_held");
        run(1'b1, 3, Z, "redebounce_wait");
        step(1'b0, 1'b1, PP, "redebounce_press");
        run(1'b1, 9, P, "relong_wait");
        step(1'b0, 1'b1, L, "relong_pulse");
        run(1'b0, 3, P, "final_release_wait");
        step(1'b0, 1'b0, R, "final_release_pulse");
        step(1'b0, 1'b0, Z, "final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
